dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters: req0 = core MEM stage, req1 = network data loader.
//  Uses the codebase valid/yumi handshake on both the request and the response legs.
//  Exactly one transaction is in flight at a time; the grant holds until its response is acknowledged.
//  Round-robin priority between the two requesters.
// PARAMETERS
//  addr_width_p   32   byte address width per requester
//  data_width_p   32   write/read data width
//  cnt_width_p    16   width of the optional conflict counter
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 asynchronous, active-low reset
//  req_valid_i    in   2                 per-requester request valid; held with fields until req_yumi_o
//  req_addr_i     in   2*addr_width_p    packed addresses, [i*addr_width_p +: addr_width_p]
//  req_wdata_i    in   2*data_width_p    packed write data
//  req_wen_i      in   2                 1 = store, 0 = load
//  req_byte_i     in   2                 byte_not_word
//  req_yumi_o     out  2                 request accepted by memory (one cycle)
//  resp_valid_o   out  2                 response valid to the granted requester
//  resp_data_o    out  data_width_p      read data (shared by both requesters)
//  resp_yumi_i    in   2                 requester acknowledges its response
//  mem_valid_o    out  1                 request valid to memory
//  mem_addr_o     out  addr_width_p      memory address
//  mem_wdata_o    out  data_width_p      memory write data
//  mem_wen_o      out  1                 memory write enable
//  mem_byte_o     out  1                 memory byte_not_word
//  mem_yumi_o     out  1                 response acknowledge to memory
//  mem_yumi_i     in   1                 memory accepted the request
//  mem_valid_i    in   1                 memory response valid; held until mem_yumi_o
//  mem_rdata_i    in   data_width_p      memory read data
//  conflict_cnt_o out  cnt_width_p       cycles with both req_valid_i set while in IDLE
// BEHAVIOUR
//  State is {IDLE, REQ, RESP}, plus grant_r (1 bit) and last_r (1 bit).
//  Reset values: state IDLE, grant_r 0, last_r 1 (so req0 wins the first tie). All outputs are 0 during reset.
//  IDLE
//   - No valid: stay in IDLE.
//   - One valid: latch grant_r = that index.
//   - Both valid: grant_r = ~last_r.
//   - On any latch, go to REQ. mem_valid_o is first asserted in the next cycle (1-cycle arbitration latency).
//  REQ
//   - mem_valid_o = 1. mem_addr_o, mem_wdata_o, mem_wen_o and mem_byte_o are muxed combinationally from requester grant_r.
//   - req_yumi_o[grant_r] = mem_yumi_i.
//   - When mem_yumi_i is seen: last_r <= grant_r, go to RESP.
//   - mem_valid_i is ignored in REQ. Memory holds it until acknowledged, so it is seen in RESP.
//  RESP
//   - mem_valid_o = 0.
//   - resp_valid_o[grant_r] = mem_valid_i and resp_data_o = mem_rdata_i; both fields are driven only in RESP.
//   - mem_yumi_o = mem_valid_i & resp_yumi_i[grant_r].
//   - When mem_yumi_o fires, go to IDLE. The next grant can be latched in that IDLE cycle.
//   - Stores also complete through RESP; resp_data_o is don't-care for stores.
//  General rules
//   - The non-granted requester never sees req_yumi_o or resp_valid_o. Its req_valid_i may stay high; it waits.
//   - Minimum transaction: IDLE -> REQ -> RESP -> IDLE, i.e. 3 cycles when memory answers immediately.
//   - Round-robin: with both requesters continuously valid, grants alternate 0, 1, 0, 1, ...
//   - A requester dropping req_valid_i in REQ before req_yumi_o is a protocol error. The arbiter does not detect it; the bench flags it.
//   - resp_yumi_i of the non-granted requester is ignored.
//   - Reset asserted mid-transaction forces IDLE immediately and abandons the in-flight access. Memory must be reset together with the arbiter.
// CONFIGURATION
//  DMEM_ARB_CONFLICT_CNT_EN
//   - Defined: conflict_cnt_o increments in each IDLE cycle with req_valid_i == 2'b11.
//     It saturates at all-ones and resets to 0.
//   - Undefined: conflict_cnt_o is tied to 0 and no counter flops are built.
//   - Arbitration behaviour is identical in both builds.
// TESTING
//  T1 Single load
//   - Stimulus: req0 valid, addr 0x10, wen 0. Memory gives yumi in the 1st REQ cycle and valid with 0xDEADBEEF 2 cycles later.
//   - Expected: req_yumi_o = 01 for one cycle; resp_valid_o = 01 with data 0xDEADBEEF; mem_yumi_o pulses when resp_yumi_i[0] = 1; back to IDLE.
//  T2 Tie after reset
//   - Stimulus: both requesters valid in the first IDLE cycle.
//   - Expected: req0 granted first (mem_addr_o = req0 addr), then req1.
//   - With DMEM_ARB_CONFLICT_CNT_EN defined, conflict_cnt_o = 1 after the first tie.
//  T3 Fairness
//   - Stimulus: both requesters held valid for 6 transactions.
//   - Expected: grant sequence 0, 1, 0, 1, 0, 1; neither requester is starved.
//  T4 Response backpressure
//   - Stimulus: hold resp_yumi_i[1] = 0 for 5 cycles while mem_valid_i = 1 on a req1 load.
//   - Expected: mem_yumi_o stays 0; state stays RESP; req0 is not granted until the acknowledge.
//  T5 Store with late yumi
//   - Stimulus: req1 store, addr 0x4, data 0x55, byte 1. Memory delays mem_yumi_i by 3 cycles.
//   - Expected: mem_valid_o = 1 with stable fields for 4 cycles; mem_wen_o = 1, mem_byte_o = 1; req_yumi_o = 10 exactly once.
//  T6 Reset mid-RESP
//   - Stimulus: assert reset (active-low) asynchronously while in RESP.
//   - Expected: outputs drop to 0 without waiting for clk; after release, the first tie grants req0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core MEM stage (req0)
// and the network data loader (req1) using valid/yumi handshakes on both legs.
// One transaction in flight at a time; round-robin priority on ties.
// Optional build macro DMEM_ARB_CONFLICT_CNT_EN adds a saturating counter of
// IDLE cycles in which both requesters are valid.
module dmem_arbiter #(
   parameter int unsigned addr_width_p = 32,
   parameter int unsigned data_width_p = 32,
   parameter int unsigned cnt_width_p  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                req_valid_i,
   input  logic [2*addr_width_p-1:0] req_addr_i,
   input  logic [2*data_width_p-1:0] req_wdata_i,
   input  logic [1:0]                req_wen_i,
   input  logic [1:0]                req_byte_i,
   output logic [1:0]                req_yumi_o,
   output logic [1:0]                resp_valid_o,
   output logic [data_width_p-1:0]   resp_data_o,
   input  logic [1:0]                resp_yumi_i,
   output logic                      mem_valid_o,
   output logic [addr_width_p-1:0]   mem_addr_o,
   output logic [data_width_p-1:0]   mem_wdata_o,
   output logic                      mem_wen_o,
   output logic                      mem_byte_o,
   output logic                      mem_yumi_o,
   input  logic                      mem_yumi_i,
   input  logic                      mem_valid_i,
   input  logic [data_width_p-1:0]   mem_rdata_i,
   output logic [cnt_width_p-1:0]    conflict_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e state_q;
   logic   grant_q;
   logic   last_q;

   // Arbitration FSM: latch a grant in IDLE, hold it through REQ and RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i != 2'b00) begin
                  // Tie goes to the requester not served last; otherwise the lone valid one
                  grant_q <= (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_yumi_i) begin
                  last_q  <= grant_q;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (mem_yumi_o) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Request/response steering toward the granted requester; zero outside its phase
   always_comb begin
      req_yumi_o   = 2'b00;
      resp_valid_o = 2'b00;
      resp_data_o  = '0;
      mem_valid_o  = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_wen_o    = 1'b0;
      mem_byte_o   = 1'b0;
      mem_yumi_o   = 1'b0;
      case (state_q)
         ST_REQ: begin
            mem_valid_o         = 1'b1;
            mem_addr_o          = grant_q ? req_addr_i[addr_width_p +: addr_width_p]
                                          : req_addr_i[0 +: addr_width_p];
            mem_wdata_o         = grant_q ? req_wdata_i[data_width_p +: data_width_p]
                                          : req_wdata_i[0 +: data_width_p];
            mem_wen_o           = req_wen_i[grant_q];
            mem_byte_o          = req_byte_i[grant_q];
            req_yumi_o[grant_q] = mem_yumi_i;
         end
         ST_RESP: begin
            resp_valid_o[grant_q] = mem_valid_i;
            resp_data_o           = mem_rdata_i;
            mem_yumi_o            = mem_valid_i & resp_yumi_i[grant_q];
         end
         default: ;
      endcase
   end

`ifdef DMEM_ARB_CONFLICT_CNT_EN
   logic [cnt_width_p-1:0] cnt_q;
   logic [cnt_width_p-1:0] cnt_d;

   // Saturating count of IDLE cycles where both requesters compete
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == ST_IDLE) && (req_valid_i == 2'b11) && (cnt_q != '1)) begin
         cnt_d = cnt_q + cnt_width_p'(1);
      end
   end

   // Conflict counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign conflict_cnt_o = cnt_q;
`else
   assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic, checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int P_FREE = 0;
   localparam int P_ACC  = 1;
   localparam int P_RSP  = 2;

   logic            clk;
   logic            reset;
   logic [1:0]      req_valid_i;
   logic [2*AW-1:0] req_addr_i;
   logic [2*DW-1:0] req_wdata_i;
   logic [1:0]      req_wen_i;
   logic [1:0]      req_byte_i;
   logic [1:0]      req_yumi_o;
   logic [1:0]      resp_valid_o;
   logic [DW-1:0]   resp_data_o;
   logic [1:0]      resp_yumi_i;
   logic            mem_valid_o;
   logic [AW-1:0]   mem_addr_o;
   logic [DW-1:0]   mem_wdata_o;
   logic            mem_wen_o;
   logic            mem_byte_o;
   logic            mem_yumi_o;
   logic            mem_yumi_i;
   logic            mem_valid_i;
   logic [DW-1:0]   mem_rdata_i;
   logic [CW-1:0]   conflict_cnt_o;

   dmem_arbiter #(.addr_width_p(AW), .data_width_p(DW), .cnt_width_p(CW)) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_wen_i(req_wen_i), .req_byte_i(req_byte_i), .req_yumi_o(req_yumi_o),
      .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
      .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o), .mem_yumi_o(mem_yumi_o),
      .mem_yumi_i(mem_yumi_i), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
      .conflict_cnt_o(conflict_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Requester side: pending request and its held fields
   bit          pend [2];
   logic [31:0] f_addr [2];
   logic [31:0] f_wdata [2];
   bit          f_wen [2];
   bit          f_byte [2];

   // Reference model of the transaction in flight
   int          m_phase, m_w, m_last, m_cnt, m_vcnt;
   int          m_ylat, m_rlat, m_blat;
   logic [31:0] m_rdata;
   int          m_conf;
   int          grant_log [$];

   // Observed statistics for scenario-level checks
   int          st_req_cycles, st_yumi0, st_yumi1, st_stall;
   logic [31:0] st_last_rdata;

   task automatic model_clear();
      pend[0] = 0; pend[1] = 0;
      m_phase = P_FREE; m_w = 0; m_last = 1; m_cnt = 0; m_vcnt = 0; m_conf = 0;
   endtask

   task automatic zero_inputs();
      req_valid_i = '0; req_addr_i = '0; req_wdata_i = '0; req_wen_i = '0; req_byte_i = '0;
      resp_yumi_i = '0; mem_yumi_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      zero_inputs();
      model_clear();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic new_req(input int i);
      pend[i]    = 1;
      f_addr[i]  = $urandom;
      f_wdata[i] = $urandom;
      f_wen[i]   = 1'($urandom_range(1));
      f_byte[i]  = 1'($urandom_range(1));
   endtask

   // Cycle engine: drives requesters and memory, checks every output against the model
   task automatic run_txns(input int n, input int gen_pct,
                           input int yl_lo, input int yl_hi, input int rl_lo, input int rl_hi,
                           input int bl_lo, input int bl_hi,
                           input bit fix_rd, input logic [31:0] rd_val);
      int done = 0;
      int cyc = 0;
      logic [1:0]  oh;
      logic        e_mv, e_wen, e_byte, e_my;
      logic [31:0] e_addr, e_wdata, e_rd;
      logic [1:0]  e_ry, e_rv;
      logic [CW-1:0] e_cnt;
      grant_log.delete();
      st_req_cycles = 0; st_yumi0 = 0; st_yumi1 = 0; st_stall = 0; st_last_rdata = '0;
      while (done < n && cyc < 2000) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if (!pend[i] && ($urandom_range(99) < 32'(gen_pct))) new_req(i);
         req_valid_i = {1'(pend[1]), 1'(pend[0])};
         req_addr_i  = {f_addr[1], f_addr[0]};
         req_wdata_i = {f_wdata[1], f_wdata[0]};
         req_wen_i   = {1'(f_wen[1]), 1'(f_wen[0])};
         req_byte_i  = {1'(f_byte[1]), 1'(f_byte[0])};
         mem_rdata_i = m_rdata;
         mem_yumi_i  = (m_phase == P_ACC) && (m_cnt >= m_ylat);
         mem_valid_i = (m_phase == P_RSP) ? (m_cnt >= m_rlat) :
                       (m_phase == P_ACC) ? 1'($urandom_range(1)) : 1'b0;
         resp_yumi_i = 2'($urandom_range(3));
         if (m_phase == P_RSP) resp_yumi_i[m_w] = mem_valid_i && (m_vcnt >= m_blat);
         #1;
         oh      = (m_w == 1) ? 2'b10 : 2'b01;
         e_mv    = (m_phase == P_ACC);
         e_addr  = e_mv ? f_addr[m_w] : 32'h0;
         e_wdata = e_mv ? f_wdata[m_w] : 32'h0;
         e_wen   = e_mv ? f_wen[m_w] : 1'b0;
         e_byte  = e_mv ? f_byte[m_w] : 1'b0;
         e_ry    = (e_mv && mem_yumi_i) ? oh : 2'b00;
         e_rv    = (m_phase == P_RSP && mem_valid_i) ? oh : 2'b00;
         e_rd    = (m_phase == P_RSP) ? m_rdata : 32'h0;
         e_my    = (m_phase == P_RSP) && mem_valid_i && resp_yumi_i[m_w];
`ifdef DMEM_ARB_CONFLICT_CNT_EN
         e_cnt   = CW'(m_conf);
`else
         e_cnt   = '0;
`endif
         tests += 9;
         if (mem_valid_o !== e_mv) begin fails++; $display("FAIL mem_valid cyc=%0d got=%b exp=%b", cyc, mem_valid_o, e_mv); end
         if ({mem_addr_o, mem_wdata_o} !== {e_addr, e_wdata}) begin fails++;
            $display("FAIL mem_fields cyc=%0d got=%h/%h exp=%h/%h", cyc, mem_addr_o, mem_wdata_o, e_addr, e_wdata); end
         if (mem_wen_o !== e_wen) begin fails++; $display("FAIL mem_wen cyc=%0d got=%b exp=%b", cyc, mem_wen_o, e_wen); end
         if (mem_byte_o !== e_byte) begin fails++; $display("FAIL mem_byte cyc=%0d got=%b exp=%b", cyc, mem_byte_o, e_byte); end
         if (req_yumi_o !== e_ry) begin fails++; $display("FAIL req_yumi cyc=%0d got=%b exp=%b", cyc, req_yumi_o, e_ry); end
         if (resp_valid_o !== e_rv) begin fails++; $display("FAIL resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid_o, e_rv); end
         if (resp_data_o !== e_rd) begin fails++; $display("FAIL resp_data cyc=%0d got=%h exp=%h", cyc, resp_data_o, e_rd); end
         if (mem_yumi_o !== e_my) begin fails++; $display("FAIL mem_yumi cyc=%0d got=%b exp=%b", cyc, mem_yumi_o, e_my); end
         if (conflict_cnt_o !== e_cnt) begin fails++; $display("FAIL conflict_cnt cyc=%0d got=%0d exp=%0d", cyc, conflict_cnt_o, e_cnt); end
         if (mem_valid_o) st_req_cycles++;
         if (req_yumi_o[0]) st_yumi0++;
         if (req_yumi_o[1]) st_yumi1++;
         if (resp_valid_o != 2'b00) begin
            st_last_rdata = resp_data_o;
            if (!mem_yumi_o) st_stall++;
         end
         // Advance the model by one clock
         case (m_phase)
            P_FREE: if (pend[0] || pend[1]) begin
               if (pend[0] && pend[1]) begin
                  m_w = 1 - m_last;
                  if (m_conf < CNT_MAX) m_conf++;
               end else m_w = pend[1] ? 1 : 0;
               m_phase = P_ACC; m_cnt = 0;
               m_ylat = $urandom_range(yl_hi, yl_lo);
               m_rlat = $urandom_range(rl_hi, rl_lo);
               m_blat = $urandom_range(bl_hi, bl_lo);
               m_rdata = fix_rd ? rd_val : $urandom;
               grant_log.push_back(m_w);
            end
            P_ACC: if (mem_yumi_i) begin
               pend[m_w] = 0; m_last = m_w; m_phase = P_RSP; m_cnt = 0; m_vcnt = 0;
            end else m_cnt++;
            default: if (e_my) begin
               m_phase = P_FREE; done++;
            end else begin
               m_cnt++;
               if (mem_valid_i) m_vcnt++;
            end
         endcase
         cyc++;
      end
      tests++;
      if (done != n) begin fails++; $display("FAIL txn_timeout done=%0d exp=%0d", done, n); end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_clear();
      for (int k = 0; k < 3; k++) begin
         req_valid_i = 2'b11; req_addr_i = {$urandom, $urandom}; req_wdata_i = {$urandom, $urandom};
         req_wen_i = 2'b11; req_byte_i = 2'b11; resp_yumi_i = 2'b11;
         mem_yumi_i = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = $urandom;
         #1;
         tests++;
         if ({req_yumi_o, resp_valid_o, resp_data_o, mem_valid_o, mem_addr_o, mem_wdata_o,
              mem_wen_o, mem_byte_o, mem_yumi_o, conflict_cnt_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got mv=%b ry=%b rv=%b addr=%h cnt=%0d exp=all-zero",
                     mem_valid_o, req_yumi_o, resp_valid_o, mem_addr_o, conflict_cnt_o);
         end
         @(negedge clk);
      end
      zero_inputs();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_single_load();
      apply_reset();
      pend[0] = 1; f_addr[0] = 32'h10; f_wdata[0] = 32'h0; f_wen[0] = 0; f_byte[0] = 0;
      run_txns(1, 0, 0, 0, 1, 1, 0, 0, 1'b1, 32'hDEADBEEF);
      tests += 3;
      if (st_yumi0 != 1 || st_yumi1 != 0) begin fails++; $display("FAIL t1_req_yumi got=%0d/%0d exp=1/0", st_yumi0, st_yumi1); end
      if (st_last_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL t1_rdata got=%h exp=deadbeef", st_last_rdata); end
      if (grant_log.size() != 1 || grant_log[0] != 0) begin fails++; $display("FAIL t1_grant got_n=%0d exp=1", grant_log.size()); end
   endtask

   task automatic test_tie_after_reset();
      apply_reset();
      new_req(0); new_req(1);
      run_txns(2, 0, 0, 1, 0, 1, 0, 1, 1'b0, 32'h0);
      tests += 2;
      if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
         fails++; $display("FAIL t2_order got_n=%0d exp=0,1", grant_log.size()); end
`ifdef DMEM_ARB_CONFLICT_CNT_EN
      if (conflict_cnt_o !== CW'(1)) begin fails++; $display("FAIL t2_conflict got=%0d exp=1", conflict_cnt_o); end
`else
      if (conflict_cnt_o !== '0) begin fails++; $display("FAIL t2_conflict got=%0d exp=0", conflict_cnt_o); end
`endif
   endtask

   task automatic test_fairness();
      apply_reset();
      run_txns(6, 100, 0, 2, 0, 2, 0, 2, 1'b0, 32'h0);
      tests++;
      if (grant_log.size() != 6) begin fails++; $display("FAIL t3_count got=%0d exp=6", grant_log.size()); end
      for (int i = 0; i < grant_log.size(); i++) begin
         tests++;
         if (grant_log[i] != i % 2) begin fails++; $display("FAIL t3_grant idx=%0d got=%0d exp=%0d", i, grant_log[i], i % 2); end
      end
   endtask

   task automatic test_resp_backpressure();
      apply_reset();
      new_req(0);
      run_txns(1, 0, 0, 0, 0, 0, 0, 0, 1'b0, 32'h0);
      new_req(0); new_req(1);
      f_wen[1] = 0;
      run_txns(2, 0, 0, 0, 0, 0, 5, 5, 1'b0, 32'h0);
      tests += 2;
      if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0) begin
         fails++; $display("FAIL t4_order got_n=%0d exp=1,0", grant_log.size()); end
      if (st_stall != 10) begin fails++; $display("FAIL t4_stall got=%0d exp=10", st_stall); end
   endtask

   task automatic test_store_late_yumi();
      apply_reset();
      pend[1] = 1; f_addr[1] = 32'h4; f_wdata[1] = 32'h55; f_wen[1] = 1; f_byte[1] = 1;
      run_txns(1, 0, 3, 3, 0, 1, 0, 1, 1'b0, 32'h0);
      tests += 2;
      if (st_req_cycles != 4) begin fails++; $display("FAIL t5_req_cycles got=%0d exp=4", st_req_cycles); end
      if (st_yumi1 != 1 || st_yumi0 != 0) begin fails++; $display("FAIL t5_req_yumi got=%0d/%0d exp=0/1", st_yumi0, st_yumi1); end
   endtask

   task automatic test_reset_mid_resp();
      apply_reset();
      @(negedge clk);
      req_valid_i = 2'b01; req_addr_i = {32'h0, 32'h100};
      @(negedge clk);
      #1;
      tests++;
      if (mem_valid_o !== 1'b1) begin fails++; $display("FAIL t6_req got=%b exp=1", mem_valid_o); end
      mem_yumi_i = 1'b1;
      @(negedge clk);
      req_valid_i = 2'b00; mem_yumi_i = 1'b0; mem_valid_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
      resp_yumi_i = 2'b01;
      #1;
      tests++;
      if ({resp_valid_o, mem_yumi_o} !== 3'b011) begin fails++; $display("FAIL t6_resp got=%b exp=011", {resp_valid_o, mem_yumi_o}); end
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({req_yumi_o, resp_valid_o, resp_data_o, mem_valid_o, mem_addr_o, mem_yumi_o} !== '0) begin
         fails++; $display("FAIL t6_async got rv=%b rd=%h my=%b exp=zero", resp_valid_o, resp_data_o, mem_yumi_o); end
      zero_inputs();
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      new_req(0); new_req(1);
      run_txns(2, 0, 0, 1, 0, 1, 0, 1, 1'b0, 32'h0);
      tests++;
      if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
         fails++; $display("FAIL t6_order got_n=%0d exp=0,1", grant_log.size()); end
   endtask

   task automatic test_random_traffic();
      apply_reset();
      run_txns(40, 35, 0, 3, 0, 3, 0, 3, 1'b0, 32'h0);
   endtask

   task automatic test_conflict_saturation();
      apply_reset();
      run_txns(20, 100, 0, 1, 0, 1, 0, 1, 1'b0, 32'h0);
      tests++;
`ifdef DMEM_ARB_CONFLICT_CNT_EN
      if (conflict_cnt_o !== CW'(CNT_MAX)) begin fails++; $display("FAIL sat_cnt got=%0d exp=%0d", conflict_cnt_o, CNT_MAX); end
`else
      if (conflict_cnt_o !== '0) begin fails++; $display("FAIL sat_cnt got=%0d exp=0", conflict_cnt_o); end
`endif
   endtask

   initial begin
      zero_inputs();
      m_rdata = '0;
      test_reset();
      test_single_load();
      test_tie_after_reset();
      test_fairness();
      test_resp_backpressure();
      test_store_late_yumi();
      test_reset_mid_resp();
      test_random_traffic();
      test_conflict_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
